// File: rtl/eros_safe_csr_responder.sv
// eros_safe_csr_responder: OBI safe CPU register window with halt/resume sequencer and mismatch interrupt
package eros_safe_csr_pkg;
    typedef enum logic {EDGE, LEVEL} interrupt_type_e;
endpackage

module eros_safe_csr_responder
    import eros_safe_csr_pkg::*;
#(
    parameter logic [31:0]     BaseAddr      = 32'h2000_0000,
    parameter int unsigned     NCores        = 3,
    parameter int unsigned     TimeoutCycles = 1024,
    parameter interrupt_type_e IntcType      = EDGE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    input  logic [NCores-1:0] halted_i,
    input  logic              mismatch_i,
    output logic [NCores-1:0] halt_req_o,
    output logic              resume_o,
    output logic [31:0]       boot_addr_o,
    output logic [1:0]        mode_o,
    output logic              irq_o
);
    localparam int unsigned Cw = $clog2(TimeoutCycles);
    localparam logic [Cw-1:0] CntLast = Cw'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, HALT, RESUME} state_e;

    state_e        state_q, state_n;
    logic [Cw-1:0] cnt_q, cnt_n;
    logic [2:0]    ctrl_q, pend_q, pend_n, w1c;
    logic [31:0]   boot_q, rdata_q, rdata_n, status, byte_mask, offset;
    logic [5:0]    idx;
    logic          sticky_q, sticky_n, mm_prev_q, rvalid_q;
    logic          wr, start, done_set, to_set, mm_set, unused_bits;

    assign offset      = addr_i - BaseAddr;
    assign idx         = offset[7:2];
    assign unused_bits = ^{offset[31:8], offset[1:0]};
    assign wr          = req_i & we_i;
    assign byte_mask   = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign start       = wr && idx == 6'h01 && be_i[0] && wdata_i[0] && state_q == IDLE;
    assign w1c         = (wr && idx == 6'h04 && be_i[0]) ? wdata_i[2:0] : 3'b000;
    assign mm_set      = (IntcType == LEVEL) ? mismatch_i : mismatch_i & ~mm_prev_q;

    always_comb begin
        status = '0;
        status[0] = state_q != IDLE;
        status[1] = sticky_q;
        status[8 +: NCores] = halted_i;
    end

    assign rdata_n = (!req_i || we_i) ? 32'h0 :
                     idx == 6'h00 ? {29'h0, ctrl_q} :
                     idx == 6'h02 ? status :
                     idx == 6'h03 ? boot_q :
                     idx == 6'h04 ? {29'h0, pend_q} : 32'h0;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        sticky_n = sticky_q;
        done_set = 1'b0;
        to_set   = 1'b0;
        unique case (state_q)
            IDLE: if (start) begin
                state_n  = HALT;
                cnt_n    = '0;
                sticky_n = 1'b0;
            end
            // completion wins over timeout when both happen in the same cycle
            HALT: if (&halted_i) begin
                state_n  = RESUME;
                done_set = 1'b1;
            end else if (cnt_q == CntLast) begin
                state_n  = IDLE;
                to_set   = 1'b1;
                sticky_n = 1'b1;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
            RESUME: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        pend_n = (pend_q & ~w1c) | {to_set, done_set, mm_set};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            pend_q    <= '0;
            ctrl_q    <= '0;
            boot_q    <= '0;
            mm_prev_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sticky_q  <= sticky_n;
            pend_q    <= pend_n;
            mm_prev_q <= mismatch_i;
            rvalid_q  <= req_i;
            rdata_q   <= rdata_n;
            if (wr && idx == 6'h00 && be_i[0]) ctrl_q <= wdata_i[2:0];
            if (wr && idx == 6'h03) boot_q <= (boot_q & ~byte_mask) | (wdata_i & byte_mask);
        end
    end

    assign gnt_o       = req_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign halt_req_o  = {NCores{state_q == HALT}};
    assign resume_o    = state_q == RESUME;
    assign boot_addr_o = boot_q;
    assign mode_o      = ctrl_q[1:0];
    assign irq_o       = ctrl_q[2] & |pend_q;
endmodule

// File: tb/tb_eros_safe_csr_responder.sv
// tb_eros_safe_csr_responder: vector table, randomized register traffic against a register model, and sequencer/IRQ corner cases
module tb_eros_safe_csr_responder;
    import eros_safe_csr_pkg::*;

    localparam logic [31:0] Base = 32'h2000_0000;

    typedef struct {
        logic        we;
        logic [7:0]  off;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    logic        clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, we_i = 1'b0, mismatch_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] addr_i = Base, wdata_i = '0;
    logic [2:0]  halted_i = '0;
    logic        gnt_o, rvalid_o, resume_o, irq_o, gnt_l, rvalid_l, resume_l, irq_l;
    logic [31:0] rdata_o, boot_addr_o, rdata_l, boot_l;
    logic [2:0]  halt_req_o, halt_req_l;
    logic [1:0]  mode_o, mode_l;

    int          vectors = 0, miscompares = 0, hi, res;
    logic [2:0]  m_ctrl = '0;
    logic [31:0] m_boot = '0, rd, rdl;
    vec_t        tv[12];

    eros_safe_csr_responder #(.BaseAddr(Base), .NCores(3), .TimeoutCycles(16), .IntcType(EDGE)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .halted_i(halted_i),
        .mismatch_i(mismatch_i), .halt_req_o(halt_req_o), .resume_o(resume_o), .boot_addr_o(boot_addr_o),
        .mode_o(mode_o), .irq_o(irq_o));

    eros_safe_csr_responder #(.BaseAddr(Base), .NCores(3), .TimeoutCycles(16), .IntcType(LEVEL)) dut_l (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_l), .rvalid_o(rvalid_l), .rdata_o(rdata_l), .halted_i(halted_i),
        .mismatch_i(mismatch_i), .halt_req_o(halt_req_l), .resume_o(resume_l), .boot_addr_o(boot_l),
        .mode_o(mode_l), .irq_o(irq_l));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    // called at a falling edge; the request is granted at the next rising edge
    task automatic bus(input logic we, input logic [7:0] off, input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] r, output logic [31:0] rl);
        req_i = 1'b1; we_i = we; addr_i = Base + 32'(off); wdata_i = wd; be_i = be;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        chk("rvalid", 32'(rvalid_o), 32'h1);
        r = rdata_o;
        rl = rdata_l;
        if (we) chk("wr_rdata", rdata_o, 32'h0);
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off >> 2)
            8'd0: return 32'(m_ctrl);
            8'd2: return 32'(halted_i) * 256;
            8'd3: return m_boot;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] be);
        if (off == 8'h00 && be[0]) m_ctrl = wd[2:0];
        if (off == 8'h0C)
            for (int b = 0; b < 4; b++)
                if (be[b]) m_boot[8*b +: 8] = wd[8*b +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1'b1, 8'h00, 32'h0000_0005, 4'hF, 32'h0};
        tv[1]  = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h5};
        tv[2]  = '{1'b1, 8'h00, 32'h0000_0002, 4'h0, 32'h0};
        tv[3]  = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h5};
        tv[4]  = '{1'b1, 8'h0C, 32'h1902_0080, 4'hF, 32'h0};
        tv[5]  = '{1'b1, 8'h0C, 32'hFFFF_FFFF, 4'h2, 32'h0};
        tv[6]  = '{1'b0, 8'h0C, 32'h0,         4'hF, 32'h1902_FF80};
        tv[7]  = '{1'b0, 8'h04, 32'h0,         4'hF, 32'h0};
        tv[8]  = '{1'b1, 8'h40, 32'hDEAD_BEEF, 4'hF, 32'h0};
        tv[9]  = '{1'b0, 8'h40, 32'h0,         4'hF, 32'h0};
        tv[10] = '{1'b1, 8'h00, 32'h0000_00FF, 4'h2, 32'h0};
        tv[11] = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h5};

        req_i = 1'b1;
        #3;
        chk("rst_gnt", 32'(gnt_o), 32'h1);
        chk("rst_halt_req", 32'(halt_req_o), 32'h0);
        chk("rst_resume", 32'(resume_o), 32'h0);
        chk("rst_boot", boot_addr_o, 32'h0);
        chk("rst_mode", 32'(mode_o), 32'h0);
        chk("rst_irq", 32'(irq_o), 32'h0);
        @(negedge clk_i);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 12; i++) begin
            bus(tv[i].we, tv[i].off, tv[i].wd, tv[i].be, rd, rdl);
            chk($sformatf("tv%0d", i), rd, tv[i].exp);
            if (tv[i].we) model_write(tv[i].off, tv[i].wd, tv[i].be);
        end
        chk("tv_mode", 32'(mode_o), 32'h1);
        chk("tv_boot", boot_addr_o, 32'h1902_FF80);
        @(negedge clk_i);
        chk("idle_rvalid", 32'(rvalid_o), 32'h0);
        chk("idle_rdata", rdata_o, 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic [7:0]  off;
            logic        we;
            logic [31:0] wd, exp;
            logic [3:0]  be;
            off = 8'($urandom_range(0, 63) << 2);
            we = 1'($urandom);
            if (off == 8'h04) we = 1'b0;
            wd = $urandom;
            be = 4'($urandom);
            halted_i = 3'($urandom);
            exp = model_read(off);
            bus(we, off, wd, be, rd, rdl);
            if (!we) begin
                chk($sformatf("rand_rd@%02h", off), rd, exp);
                chk($sformatf("rand_rd_l@%02h", off), rdl, exp);
            end else begin
                model_write(off, wd, be);
            end
            chk("rand_mode", 32'(mode_o), 32'(m_ctrl[1:0]));
            chk("rand_boot", boot_addr_o, m_boot);
            chk("rand_irq", 32'(irq_o), 32'h0);
        end
        halted_i = '0;
        bus(1'b1, 8'h00, 32'h4, 4'hF, rd, rdl);

        // sync completes after the cores report halted
        bus(1'b1, 8'h04, 32'h1, 4'h1, rd, rdl);
        chk("sync_halt_rise", 32'(halt_req_o), 32'h7);
        bus(1'b0, 8'h08, 32'h0, 4'hF, rd, rdl);
        chk("sync_busy", rd, 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("sync_halt_hold", 32'(halt_req_o), 32'h7);
            chk("sync_no_resume", 32'(resume_o), 32'h0);
        end
        halted_i = 3'b111;
        @(negedge clk_i);
        chk("sync_resume", 32'(resume_o), 32'h1);
        chk("sync_halt_drop", 32'(halt_req_o), 32'h0);
        chk("sync_irq", 32'(irq_o), 32'h1);
        @(negedge clk_i);
        chk("sync_resume_end", 32'(resume_o), 32'h0);
        halted_i = '0;
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("sync_pend", rd, 32'h2);
        bus(1'b0, 8'h08, 32'h0, 4'hF, rd, rdl);
        chk("sync_status", rd, 32'h0);
        bus(1'b1, 8'h10, 32'h2, 4'h1, rd, rdl);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("sync_pend_clr", rd, 32'h0);
        chk("sync_irq_clr", 32'(irq_o), 32'h0);

        // timeout with one core never halting
        halted_i = 3'b011;
        bus(1'b1, 8'h04, 32'h1, 4'h1, rd, rdl);
        hi = 0;
        res = 0;
        for (int i = 0; i < 40; i++) begin
            if (halt_req_o == 3'b111) hi++;
            if (resume_o) res++;
            @(negedge clk_i);
        end
        chk("to_halt_cycles", 32'(hi), 32'd16);
        chk("to_no_resume", 32'(res), 32'd0);
        bus(1'b0, 8'h08, 32'h0, 4'hF, rd, rdl);
        chk("to_status", rd, 32'h302);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("to_pend", rd, 32'h4);
        chk("to_irq", 32'(irq_o), 32'h1);
        bus(1'b1, 8'h10, 32'h4, 4'h1, rd, rdl);
        bus(1'b0, 8'h08, 32'h0, 4'hF, rd, rdl);
        chk("to_sticky_kept", rd, 32'h302);
        halted_i = '0;

        // mismatch held high: W1C sticks in EDGE, is overridden in LEVEL
        mismatch_i = 1'b1;
        repeat (3) @(negedge clk_i);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("mm_edge_set", rd, 32'h1);
        chk("mm_level_set", rdl, 32'h1);
        bus(1'b1, 8'h10, 32'h1, 4'h1, rd, rdl);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("mm_edge_cleared", rd, 32'h0);
        chk("mm_level_reset", rdl, 32'h1);
        repeat (3) @(negedge clk_i);
        mismatch_i = 1'b0;
        @(negedge clk_i);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("mm_edge_after", rd, 32'h0);
        chk("mm_level_after", rdl, 32'h1);
        chk("mm_irq_edge", 32'(irq_o), 32'h0);
        chk("mm_irq_level", 32'(irq_l), 32'h1);
        bus(1'b1, 8'h10, 32'h1, 4'h1, rd, rdl);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("mm_level_clr", rdl, 32'h0);
        mismatch_i = 1'b1;
        bus(1'b1, 8'h10, 32'h1, 4'h1, rd, rdl);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("mm_set_wins", rd, 32'h1);
        mismatch_i = 1'b0;
        bus(1'b1, 8'h10, 32'h1, 4'h1, rd, rdl);
        bus(1'b0, 8'h10, 32'h0, 4'hF, rd, rdl);
        chk("mm_final_clr", rd, 32'h0);

        // asynchronous reset in the middle of HALT
        bus(1'b1, 8'h04, 32'h1, 4'h1, rd, rdl);
        repeat (2) @(negedge clk_i);
        chk("arst_pre_halt", 32'(halt_req_o), 32'h7);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_halt_drop", 32'(halt_req_o), 32'h0);
        chk("arst_halt_drop_l", 32'(halt_req_l), 32'h0);
        chk("arst_no_resume", 32'(resume_o), 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("arst_resume_quiet", 32'(resume_o), 32'h0);
        end
        bus(1'b0, 8'h08, 32'h0, 4'hF, rd, rdl);
        chk("arst_status", rd & 32'h3, 32'h0);
        bus(1'b0, 8'h00, 32'h0, 4'hF, rd, rdl);
        chk("arst_ctrl", rd, 32'h0);
        chk("arst_boot", boot_addr_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
